fpu_issue_scheduler: RTL

Issue controller for the shared pipelined floating-point add/sub datapath. It arbitrates between two operand requesters and drives one registered issue slot into the non-stallable pipeline. It tracks each in-flight operation with a valid/ID shift register. Results land in a credit-protected output FIFO, so downstream backpressure never drops a result.

---
 rtl/fpu_sched_pkg.sv | 15 +
 rtl/fpu_result_fifo.sv | 60 ++++++
 rtl/fpu_issue_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FP add/sub issue scheduler and its datapath wrapper.
package fpu_sched_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_LATENCY   = 3;
    localparam int DEF_OUT_DEPTH = 4;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO, any depth >= 2; head is registered storage, no empty bypass.
// Push and pop in one cycle are both honoured; push when full is accepted only alongside a pop.
module fpu_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_vld && !empty;
        do_push  = push_vld && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        // explicit wrap so non-power-of-two depths work
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fpu_issue_scheduler.sv
// Two-requester issue slot for the non-stallable FP add/sub pipe; result lands in the FIFO 1+LATENCY edges after accept.
// Credits (in flight + queued) gate Ready, so results are never dropped; FPU_SCHED_FIXED_PRIO_EN selects fixed priority.
module fpu_issue_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_SIZE-1:0] req0_operand1,
    input  logic [DATA_SIZE-1:0] req0_operand2,
    input  logic                 req0_operation,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_SIZE-1:0] req1_operand1,
    input  logic [DATA_SIZE-1:0] req1_operand2,
    input  logic                 req1_operation,
    output logic                 issue_valid,
    output logic [DATA_SIZE-1:0] issue_operand1,
    output logic [DATA_SIZE-1:0] issue_operand2,
    output logic                 issue_operation,
    input  logic [DATA_SIZE-1:0] pipe_result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [DATA_SIZE-1:0] result_data,
    output req_id_t              result_id
);
    localparam int CRED_W = $clog2(OUT_DEPTH + 1);

    logic [CRED_W-1:0]    credits_q, credits_d;
    logic                 can_issue, accept, pop;
    req_id_t              winner;
    logic                 issue_valid_q, issue_valid_d;
    logic                 issue_op_q, issue_op_d;
    req_id_t              issue_id_q, issue_id_d;
    logic [DATA_SIZE-1:0] issue_op1_q, issue_op1_d, issue_op2_q, issue_op2_d;
    logic [LATENCY-1:0]   tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
    logic                 fifo_push, fifo_full, fifo_empty;
    logic [DATA_SIZE:0]   fifo_head;

`ifdef FPU_SCHED_FIXED_PRIO_EN
    always_comb winner = (req1_valid && !req0_valid) ? REQ1 : REQ0;
`else
    req_id_t last_grant_q, last_grant_d;

    always_comb begin
        if (req0_valid && req1_valid) winner = (last_grant_q == REQ0) ? REQ1 : REQ0;
        else if (req1_valid)          winner = REQ1;
        else                          winner = REQ0;
    end

    always_comb last_grant_d = accept ? winner : last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= REQ1;
        else        last_grant_q <= last_grant_d;
    end
`endif

    always_comb begin
        can_issue  = credits_q < CRED_W'(OUT_DEPTH);
        req0_ready = rst_n && can_issue && (winner == REQ0);
        req1_ready = rst_n && can_issue && (winner == REQ1);
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        pop        = result_valid && result_ready;
        credits_d  = credits_q + CRED_W'(accept) - CRED_W'(pop);

        issue_valid_d = accept;
        issue_id_d    = issue_id_q;
        issue_op_d    = issue_op_q;
        issue_op1_d   = issue_op1_q;
        issue_op2_d   = issue_op2_q;
        if (accept) begin
            issue_id_d  = winner;
            issue_op_d  = (winner == REQ1) ? req1_operation : req0_operation;
            issue_op1_d = (winner == REQ1) ? req1_operand1  : req0_operand1;
            issue_op2_d = (winner == REQ1) ? req1_operand2  : req0_operand2;
        end

        // tags trail the issue slot so the exit stage lines up with the pipe output
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = issue_valid_q;
        tag_id_d[0]  = issue_id_q;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q     <= '0;
            issue_valid_q <= 1'b0;
            issue_id_q    <= REQ0;
            issue_op_q    <= OP_ADD;
            issue_op1_q   <= '0;
            issue_op2_q   <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
        end else begin
            credits_q     <= credits_d;
            issue_valid_q <= issue_valid_d;
            issue_id_q    <= issue_id_d;
            issue_op_q    <= issue_op_d;
            issue_op1_q   <= issue_op1_d;
            issue_op2_q   <= issue_op2_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
        end
    end

    assign fifo_push = tag_vld_q[LATENCY-1];

    fpu_result_fifo #(
        .WIDTH (DATA_SIZE + 1),
        .DEPTH (OUT_DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (fifo_push),
        .push_dat ({tag_id_q[LATENCY-1], pipe_result}),
        .pop_vld  (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

    assign issue_valid     = issue_valid_q;
    assign issue_operand1  = issue_op1_q;
    assign issue_operand2  = issue_op2_q;
    assign issue_operation = issue_op_q;
    assign result_valid    = !fifo_empty;
    assign result_data     = fifo_head[DATA_SIZE-1:0];
    assign result_id       = fifo_head[DATA_SIZE];

endmodule
